// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, tracker states and count-sequence helper shared by seg7 blocks.
package seg7_pkg;
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   // Element i holds the code for hex digit i.
   localparam logic [15:0][6:0] SEG_CODES = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                             SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
   typedef enum logic {IDLE, TRACK} trk_state_e;
   function automatic logic [3:0] next_digit(input logic [3:0] d, input logic [3:0] wrap);
      return (d >= wrap) ? 4'd0 : d + 4'd1;
   endfunction
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps a segment pattern to its hex digit, flagging table hits and the blank pattern.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] digit_o,
   output logic       hit_o,
   output logic       is_blank_o
);
   always_comb begin
      digit_o = 4'd0;
      hit_o   = 1'b0;
      for (int i = 0; i < 16; i++)
         if (pattern_i == SEG_CODES[i]) begin
            digit_o = 4'(i);
            hit_o   = 1'b1;
         end
   end
   assign is_blank_o = pattern_i == SEG_BLANK;
endmodule

// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: synchronizes and debounces a segment bus, decodes digits and
// checks them against the driver's 0..wrap_max count sequence.
module seg7_rx_monitor
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   input  logic [3:0] wrap_max,
   input  logic       clear_err,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       blank,
   output logic       unknown,
   output logic       seq_ok,
   output logic       seq_err,
   output logic [7:0] err_count
);
   logic [6:0] s1_q, s2_q, last_q, last_d;
   logic [7:0] cnt_q, cnt_d, errc_q, errc_d;
   logic [3:0] exp_q, exp_d, digit_q, digit_d, dec_digit;
   logic       dv_q, dv_d, blank_q, blank_d, unk_q, unk_d, ok_q, ok_d, err_q, err_d;
   logic       dec_hit, dec_blank, accept;
   trk_state_e state_q, state_d;

   seg7_pattern_decode u_dec (
      .pattern_i  (s2_q),
      .digit_o    (dec_digit),
      .hit_o      (dec_hit),
      .is_blank_o (dec_blank)
   );

   // cnt_q is the number of consecutive samples s2_q has held its current value.
   assign cnt_d  = (s1_q != s2_q) ? 8'd1 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign accept = (cnt_q >= 8'(STABLE_CYCLES)) && (s2_q != last_q);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      digit_d = digit_q;
      blank_d = blank_q;
      last_d  = last_q;
      dv_d    = 1'b0;
      unk_d   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      if (accept) begin
         last_d  = s2_q;
         blank_d = dec_blank;
         if (dec_hit) begin
            digit_d = dec_digit;
            dv_d    = 1'b1;
            state_d = TRACK;
            exp_d   = next_digit(dec_digit, wrap_max);
            ok_d    = (state_q == TRACK) && (dec_digit == exp_q);
            err_d   = (state_q == TRACK) && (dec_digit != exp_q);
         end else begin
            state_d = IDLE;
            unk_d   = !dec_blank;
         end
      end
      errc_d = clear_err ? 8'd0 : (err_d && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         cnt_q   <= '0;
         last_q  <= SEG_BLANK;
         state_q <= IDLE;
         exp_q   <= '0;
         digit_q <= '0;
         dv_q    <= 1'b0;
         blank_q <= 1'b1;
         unk_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         errc_q  <= '0;
      end else begin
         s1_q    <= seg_in;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         state_q <= state_d;
         exp_q   <= exp_d;
         digit_q <= digit_d;
         dv_q    <= dv_d;
         blank_q <= blank_d;
         unk_q   <= unk_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         errc_q  <= errc_d;
      end
   end

   assign digit       = digit_q;
   assign digit_valid = dv_q;
   assign blank       = blank_q;
   assign unknown     = unk_q;
   assign seq_ok      = ok_q;
   assign seq_err     = err_q;
   assign err_count   = errc_q;
endmodule

// File: tb/tb_seg7_rx_monitor.sv
// tb_seg7_rx_monitor: randomized and directed checks against a sliding-window reference model.
module tb_seg7_rx_monitor;
   localparam int S = 4;
   logic       clk = 0, reset = 1, clear_err = 0;
   logic [6:0] seg_in = 7'h00;
   logic [3:0] wrap_max = 4'd5;
   logic [3:0] digit;
   logic       digit_valid, blank, unknown, seq_ok, seq_err;
   logic [7:0] err_count;

   seg7_rx_monitor #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .wrap_max(wrap_max), .clear_err(clear_err),
      .digit(digit), .digit_valid(digit_valid), .blank(blank), .unknown(unknown),
      .seq_ok(seq_ok), .seq_err(seq_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int checks = 0, errors = 0;
   int dv_seen = 0, ok_seen = 0, err_seen = 0, unk_seen = 0;
   int m_digit, m_dv, m_blank, m_unk, m_ok, m_err, m_errc, m_exp, md;
   bit m_tracking, macc;
   logic [6:0] m_last, mp;
   logic [6:0] hist [S+1];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // hist[0] is the input sampled on the previous edge, hist[k] the one k edges before that.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_digit = 0; m_dv = 0; m_blank = 1; m_unk = 0; m_ok = 0; m_err = 0; m_errc = 0;
         m_exp = 0; m_tracking = 0; m_last = 7'h00;
         for (int i = 0; i <= S; i++) hist[i] = 7'h00;
      end else begin
         macc = hist[1] != m_last;
         for (int i = 1; i <= S; i++) if (hist[i] != hist[1]) macc = 0;
         m_dv = 0; m_unk = 0; m_ok = 0; m_err = 0;
         if (macc) begin
            mp = hist[1];
            m_last = mp;
            md = -1;
            for (int i = 0; i < 16; i++) if (tab[i] == mp) md = i;
            if (md >= 0) begin
               m_digit = md; m_dv = 1; m_blank = 0;
               if (m_tracking) begin
                  m_ok = (md == m_exp);
                  m_err = (md != m_exp);
               end
               m_tracking = 1;
               m_exp = (md >= int'(wrap_max)) ? 0 : md + 1;
            end else begin
               m_tracking = 0;
               m_blank = (mp == 7'h00);
               m_unk = (mp != 7'h00);
            end
         end
         if (clear_err) m_errc = 0;
         else if (m_err == 1 && m_errc < 255) m_errc++;
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = seg_in;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("digit", int'(digit), m_digit);
         chk("digit_valid", int'(digit_valid), m_dv);
         chk("blank", int'(blank), m_blank);
         chk("unknown", int'(unknown), m_unk);
         chk("seq_ok", int'(seq_ok), m_ok);
         chk("seq_err", int'(seq_err), m_err);
         chk("err_count", int'(err_count), m_errc);
         dv_seen  += int'(digit_valid);
         ok_seen  += int'(seq_ok);
         err_seen += int'(seq_err);
         unk_seen += int'(unknown);
      end
   end

   task automatic hold(input logic [6:0] p, input int n);
      seg_in = p;
      repeat (n) @(negedge clk);
   endtask

   int dv0, ok0, er0, un0;
   task automatic snap();
      dv0 = dv_seen; ok0 = ok_seen; er0 = err_seen; un0 = unk_seen;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_blank", int'(blank), 1);
      chk("rst_digit", int'(digit), 0);
      chk("rst_errc", int'(err_count), 0);
      chk("rst_dv", int'(digit_valid), 0);
      reset = 0;
      @(negedge clk);
      snap();
      foreach (tab[i]) if (i < 6) hold(tab[i], 10);
      hold(7'h3F, 10);
      chk("p1_ok", ok_seen - ok0, 6);
      chk("p1_err", err_seen - er0, 0);
      chk("p1_dv", dv_seen - dv0, 7);
      chk("p1_digit", int'(digit), 0);
      snap();
      hold(7'h06, 10);
      hold(7'h4F, 10);
      chk("p2_errc", int'(err_count), 1);
      chk("p2_err", err_seen - er0, 1);
      hold(7'h66, 10);
      chk("p2_ok", ok_seen - ok0, 2);
      snap();
      hold(7'h06, 10);
      hold(7'h7F, 3);
      hold(7'h06, 10);
      chk("p3_dv", dv_seen - dv0, 1);
      chk("p3_digit", int'(digit), 1);
      snap();
      hold(7'h01, 10);
      chk("p4_unk", unk_seen - un0, 1);
      hold(7'h5B, 10);
      chk("p4_digit", int'(digit), 2);
      chk("p4_seq", (ok_seen - ok0) + (err_seen - er0), 0);
      clear_err = 1;
      @(negedge clk);
      clear_err = 0;
      for (int i = 0; i < 260; i++) hold((i % 2 == 0) ? 7'h3F : 7'h5B, 6);
      chk("p5_sat", int'(err_count), 255);
      seg_in = 7'h3F;
      repeat (5) @(negedge clk);
      clear_err = 1;
      @(negedge clk);
      clear_err = 0;
      chk("p5_clr_seqerr", int'(seq_err), 1);
      chk("p5_clr_errc", int'(err_count), 0);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if ($urandom_range(0, 15) == 0) wrap_max = 4'($urandom_range(0, 15));
         clear_err = ($urandom_range(0, 9) == 0);
         hold((r < 16) ? tab[r] : (r == 16) ? 7'h00 : 7'($urandom_range(0, 127)), $urandom_range(1, 9));
      end
      clear_err = 0;
      wrap_max = 4'd5;
      hold(7'h06, 10);
      hold(7'h4F, 10);
      chk("p7_pre_errc", int'(err_count != 0), 1);
      #2 reset = 1;
      #1;
      chk("p7_blank", int'(blank), 1);
      chk("p7_digit", int'(digit), 0);
      chk("p7_errc", int'(err_count), 0);
      chk("p7_dv", int'(digit_valid), 0);
      repeat (2) @(negedge clk);
      #2 reset = 0;
      @(negedge clk);
      snap();
      hold(7'h66, 10);
      chk("p7_dv_after", dv_seen - dv0, 1);
      chk("p7_seq_after", (ok_seen - ok0) + (err_seen - er0), 0);
      chk("p7_digit_after", int'(digit), 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
